// File: rtl/cache_mux_types.sv
// Shared types for the data-cache controller:
// array mux selects, FSM states, PLRU tree bit positions.
package cache_mux_types;

  typedef enum logic [1:0] {
    no_write        = 2'd0,
    cpu_write_cache = 2'd1,
    mem_write_cache = 2'd2
  } dataarraymux_sel_t;

  typedef enum logic {
    cache_read_mem  = 1'b0,
    cache_write_mem = 1'b1
  } pmemaddressmux_sel_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    REFETCH   = 3'd4
  } p_d_cache_state_t;

  // Tree bits: root picks half, left covers w0/w1, right w2/w3
  localparam int PLRU_ROOT  = 2;
  localparam int PLRU_LEFT  = 1;
  localparam int PLRU_RIGHT = 0;

endpackage

// File: rtl/p_d_cache_plru.sv
// 4-way pseudo-LRU: victim choice and tree update
// for the set currently being looked up.
module p_d_cache_plru
  import cache_mux_types::*;
(
  input  logic [2:0] i_lru,
  input  logic [3:0] i_valid,
  input  logic [1:0] i_way,
  output logic [1:0] o_victim,
  output logic [2:0] o_lru
);

  always_comb begin
    o_lru = i_lru;
    o_lru[PLRU_ROOT] = i_way[1];
    if (!i_way[1])
      o_lru[PLRU_LEFT] = i_way[0];
    else
      o_lru[PLRU_RIGHT] = i_way[0];
  end

  // Empty ways are always filled before evicting
  always_comb begin
    if (!i_valid[0])
      o_victim = 2'd0;
    else if (!i_valid[1])
      o_victim = 2'd1;
    else if (!i_valid[2])
      o_victim = 2'd2;
    else if (!i_valid[3])
      o_victim = 2'd3;
    else if (!i_lru[PLRU_ROOT])
      o_victim = {1'b1, ~i_lru[PLRU_RIGHT]};
    else
      o_victim = {1'b0, ~i_lru[PLRU_LEFT]};
  end

endmodule

// File: rtl/p_d_cache_control.sv
// Data-cache controller FSM: lookup, writeback, fill, refetch.
// DCACHE_PERF_CNT_EN adds saturating hit/miss counters.
module p_d_cache_control
  import cache_mux_types::*;
(
  input  logic clk,
  input  logic rst,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic req_valid,
  input  logic req_read,
  input  logic req_write,
  input  logic hit,
  input  logic way_0_hit,
  input  logic way_1_hit,
  input  logic way_2_hit,
  input  logic way_3_hit,
  input  logic v_array_0_dataout,
  input  logic v_array_1_dataout,
  input  logic v_array_2_dataout,
  input  logic v_array_3_dataout,
  input  logic dirty_out,
  input  logic [2:0] LRU_array_dataout,
  input  logic pmem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic mem_resp,
  output logic stall,
  output logic read_array_flag,
  output logic v_array_0_load,
  output logic v_array_1_load,
  output logic v_array_2_load,
  output logic v_array_3_load,
  output logic d_array_0_load,
  output logic d_array_1_load,
  output logic d_array_2_load,
  output logic d_array_3_load,
  output logic tag_array_0_load,
  output logic tag_array_1_load,
  output logic tag_array_2_load,
  output logic tag_array_3_load,
  output logic v_array_0_datain,
  output logic v_array_1_datain,
  output logic v_array_2_datain,
  output logic v_array_3_datain,
  output logic d_array_0_datain,
  output logic d_array_1_datain,
  output logic d_array_2_datain,
  output logic d_array_3_datain,
  output logic LRU_array_load,
  output logic [2:0] LRU_array_datain,
  output dataarraymux_sel_t write_en_0_MUX_sel,
  output dataarraymux_sel_t write_en_1_MUX_sel,
  output dataarraymux_sel_t write_en_2_MUX_sel,
  output dataarraymux_sel_t write_en_3_MUX_sel,
  output dataarraymux_sel_t data_array_0_datain_MUX_sel,
  output dataarraymux_sel_t data_array_1_datain_MUX_sel,
  output dataarraymux_sel_t data_array_2_datain_MUX_sel,
  output dataarraymux_sel_t data_array_3_datain_MUX_sel,
  output logic [1:0] dataout_MUX_sel,
  output pmemaddressmux_sel_t pmem_address_MUX_sel
);

  p_d_cache_state_t r_state, w_next;
  logic [1:0] r_victim, w_victim, w_hit_way;
  logic [2:0] w_lru_next;
  logic [3:0] w_valid;
  logic [3:0] w_v_load, w_v_din;
  logic [3:0] w_d_load, w_d_din, w_tag_load;
  logic w_req, w_hit_cmp, w_miss;
  dataarraymux_sel_t w_we_sel [4];
  dataarraymux_sel_t w_din_sel [4];

  assign w_valid = {v_array_3_dataout, v_array_2_dataout,
                    v_array_1_dataout, v_array_0_dataout};
  assign w_hit_way = {way_3_hit | way_2_hit,
                      way_3_hit | way_1_hit};
  assign w_req = req_read | req_write;
  assign w_hit_cmp = (r_state == COMPARE) & hit;
  assign w_miss = (r_state == COMPARE) & ~hit & w_req;

  p_d_cache_plru u_plru (
    .i_lru    (LRU_array_dataout),
    .i_valid  (w_valid),
    .i_way    (w_hit_way),
    .o_victim (w_victim),
    .o_lru    (w_lru_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_victim <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_miss)
        r_victim <= w_victim;
    end
  end

  // Outputs are gated by reset so they drop without a clock
  always_comb begin
    w_next = r_state;
    read_array_flag = 1'b0;
    mem_resp = 1'b0;
    stall = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    LRU_array_load = 1'b0;
    LRU_array_datain = 3'd0;
    dataout_MUX_sel = 2'd0;
    pmem_address_MUX_sel = cache_read_mem;
    w_v_load = 4'd0;
    w_v_din = 4'd0;
    w_d_load = 4'd0;
    w_d_din = 4'd0;
    w_tag_load = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_we_sel[i] = no_write;
      w_din_sel[i] = no_write;
    end
    if (rst) begin
      unique case (r_state)
        IDLE: begin
          read_array_flag = 1'b1;
          if (req_valid)
            w_next = COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            mem_resp = 1'b1;
            LRU_array_load = 1'b1;
            LRU_array_datain = w_lru_next;
            dataout_MUX_sel = w_hit_way;
            if (req_write) begin
              w_we_sel[w_hit_way] = cpu_write_cache;
              w_din_sel[w_hit_way] = cpu_write_cache;
              w_d_load[w_hit_way] = 1'b1;
              w_d_din[w_hit_way] = 1'b1;
            end
            w_next = req_valid ? COMPARE : IDLE;
          end else begin
            stall = 1'b1;
            if (w_req)
              w_next = dirty_out ? WRITEBACK : FILL;
            else
              w_next = IDLE;
          end
        end
        WRITEBACK: begin
          stall = 1'b1;
          pmem_write = 1'b1;
          pmem_address_MUX_sel = cache_write_mem;
          dataout_MUX_sel = r_victim;
          if (pmem_resp)
            w_next = FILL;
        end
        FILL: begin
          stall = 1'b1;
          pmem_read = 1'b1;
          if (pmem_resp) begin
            w_we_sel[r_victim] = mem_write_cache;
            w_din_sel[r_victim] = mem_write_cache;
            w_tag_load[r_victim] = 1'b1;
            w_v_load[r_victim] = 1'b1;
            w_v_din[r_victim] = 1'b1;
            w_d_load[r_victim] = 1'b1;
            w_next = REFETCH;
          end
        end
        REFETCH: begin
          stall = 1'b1;
          read_array_flag = 1'b1;
          w_next = COMPARE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign {v_array_3_load, v_array_2_load,
          v_array_1_load, v_array_0_load} = w_v_load;
  assign {v_array_3_datain, v_array_2_datain,
          v_array_1_datain, v_array_0_datain} = w_v_din;
  assign {d_array_3_load, d_array_2_load,
          d_array_1_load, d_array_0_load} = w_d_load;
  assign {d_array_3_datain, d_array_2_datain,
          d_array_1_datain, d_array_0_datain} = w_d_din;
  assign {tag_array_3_load, tag_array_2_load,
          tag_array_1_load, tag_array_0_load} = w_tag_load;
  assign write_en_0_MUX_sel = w_we_sel[0];
  assign write_en_1_MUX_sel = w_we_sel[1];
  assign write_en_2_MUX_sel = w_we_sel[2];
  assign write_en_3_MUX_sel = w_we_sel[3];
  assign data_array_0_datain_MUX_sel = w_din_sel[0];
  assign data_array_1_datain_MUX_sel = w_din_sel[1];
  assign data_array_2_datain_MUX_sel = w_din_sel[2];
  assign data_array_3_datain_MUX_sel = w_din_sel[3];

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_hit_cmp && r_hit_cnt != 32'hFFFF_FFFF)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && r_miss_cnt != 32'hFFFF_FFFF)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_p_d_cache_control.sv
// Directed + randomized bench for p_d_cache_control with a
// transaction-level cache-controller reference model.
module tb_p_d_cache_control;
  import cache_mux_types::*;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_read, req_write, hit;
  logic way_0_hit, way_1_hit, way_2_hit, way_3_hit;
  logic v_array_0_dataout, v_array_1_dataout;
  logic v_array_2_dataout, v_array_3_dataout;
  logic dirty_out, pmem_resp;
  logic [2:0] LRU_array_dataout;
  logic pmem_read, pmem_write, mem_resp, stall, read_array_flag;
  logic v_array_0_load, v_array_1_load, v_array_2_load, v_array_3_load;
  logic d_array_0_load, d_array_1_load, d_array_2_load, d_array_3_load;
  logic tag_array_0_load, tag_array_1_load;
  logic tag_array_2_load, tag_array_3_load;
  logic v_array_0_datain, v_array_1_datain;
  logic v_array_2_datain, v_array_3_datain;
  logic d_array_0_datain, d_array_1_datain;
  logic d_array_2_datain, d_array_3_datain;
  logic LRU_array_load;
  logic [2:0] LRU_array_datain;
  dataarraymux_sel_t write_en_0_MUX_sel, write_en_1_MUX_sel;
  dataarraymux_sel_t write_en_2_MUX_sel, write_en_3_MUX_sel;
  dataarraymux_sel_t data_array_0_datain_MUX_sel;
  dataarraymux_sel_t data_array_1_datain_MUX_sel;
  dataarraymux_sel_t data_array_2_datain_MUX_sel;
  dataarraymux_sel_t data_array_3_datain_MUX_sel;
  logic [1:0] dataout_MUX_sel;
  pmemaddressmux_sel_t pmem_address_MUX_sel;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
  int exp_hits, exp_misses;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  p_d_cache_control dut (
    .clk(clk),
    .rst(rst),
`ifdef DCACHE_PERF_CNT_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .req_valid(req_valid),
    .req_read(req_read),
    .req_write(req_write),
    .hit(hit),
    .way_0_hit(way_0_hit),
    .way_1_hit(way_1_hit),
    .way_2_hit(way_2_hit),
    .way_3_hit(way_3_hit),
    .v_array_0_dataout(v_array_0_dataout),
    .v_array_1_dataout(v_array_1_dataout),
    .v_array_2_dataout(v_array_2_dataout),
    .v_array_3_dataout(v_array_3_dataout),
    .dirty_out(dirty_out),
    .LRU_array_dataout(LRU_array_dataout),
    .pmem_resp(pmem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .mem_resp(mem_resp),
    .stall(stall),
    .read_array_flag(read_array_flag),
    .v_array_0_load(v_array_0_load),
    .v_array_1_load(v_array_1_load),
    .v_array_2_load(v_array_2_load),
    .v_array_3_load(v_array_3_load),
    .d_array_0_load(d_array_0_load),
    .d_array_1_load(d_array_1_load),
    .d_array_2_load(d_array_2_load),
    .d_array_3_load(d_array_3_load),
    .tag_array_0_load(tag_array_0_load),
    .tag_array_1_load(tag_array_1_load),
    .tag_array_2_load(tag_array_2_load),
    .tag_array_3_load(tag_array_3_load),
    .v_array_0_datain(v_array_0_datain),
    .v_array_1_datain(v_array_1_datain),
    .v_array_2_datain(v_array_2_datain),
    .v_array_3_datain(v_array_3_datain),
    .d_array_0_datain(d_array_0_datain),
    .d_array_1_datain(d_array_1_datain),
    .d_array_2_datain(d_array_2_datain),
    .d_array_3_datain(d_array_3_datain),
    .LRU_array_load(LRU_array_load),
    .LRU_array_datain(LRU_array_datain),
    .write_en_0_MUX_sel(write_en_0_MUX_sel),
    .write_en_1_MUX_sel(write_en_1_MUX_sel),
    .write_en_2_MUX_sel(write_en_2_MUX_sel),
    .write_en_3_MUX_sel(write_en_3_MUX_sel),
    .data_array_0_datain_MUX_sel(data_array_0_datain_MUX_sel),
    .data_array_1_datain_MUX_sel(data_array_1_datain_MUX_sel),
    .data_array_2_datain_MUX_sel(data_array_2_datain_MUX_sel),
    .data_array_3_datain_MUX_sel(data_array_3_datain_MUX_sel),
    .dataout_MUX_sel(dataout_MUX_sel),
    .pmem_address_MUX_sel(pmem_address_MUX_sel)
  );

  logic [3:0] v_ld, v_di, d_ld, d_di, t_ld;
  logic [7:0] we_pk, din_pk;
  assign v_ld = {v_array_3_load, v_array_2_load,
                 v_array_1_load, v_array_0_load};
  assign v_di = {v_array_3_datain, v_array_2_datain,
                 v_array_1_datain, v_array_0_datain};
  assign d_ld = {d_array_3_load, d_array_2_load,
                 d_array_1_load, d_array_0_load};
  assign d_di = {d_array_3_datain, d_array_2_datain,
                 d_array_1_datain, d_array_0_datain};
  assign t_ld = {tag_array_3_load, tag_array_2_load,
                 tag_array_1_load, tag_array_0_load};
  assign we_pk = {write_en_3_MUX_sel, write_en_2_MUX_sel,
                  write_en_1_MUX_sel, write_en_0_MUX_sel};
  assign din_pk = {data_array_3_datain_MUX_sel,
                   data_array_2_datain_MUX_sel,
                   data_array_1_datain_MUX_sel,
                   data_array_0_datain_MUX_sel};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: access to way w sets the tree bits on its path
  function automatic logic [2:0] model_upd(input logic [2:0] l,
                                           input int w);
    case (w)
      0: return {2'b00, l[0]};
      1: return {2'b01, l[0]};
      2: return {1'b1, l[1], 1'b0};
      default: return {1'b1, l[1], 1'b1};
    endcase
  endfunction

  function automatic int model_victim(input logic [2:0] l,
                                      input logic [3:0] vld);
    int tbl [8];
    tbl = '{3, 2, 3, 2, 1, 1, 0, 0};
    for (int i = 0; i < 4; i++)
      if (!vld[i]) return i;
    return tbl[l];
  endfunction

  function automatic logic [7:0] selv(input int w,
                                      input dataarraymux_sel_t s);
    logic [7:0] r;
    r = 8'd0;
    if (w >= 0) r[2*w +: 2] = s;
    return r;
  endfunction

  function automatic logic [3:0] oneh(input int w);
    return (w >= 0) ? 4'(1 << w) : 4'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_meta(input int hw, input logic [3:0] vld,
                          input bit dty, input logic [2:0] lru);
    hit = (hw >= 0);
    way_0_hit = (hw == 0);
    way_1_hit = (hw == 1);
    way_2_hit = (hw == 2);
    way_3_hit = (hw == 3);
    {v_array_3_dataout, v_array_2_dataout,
     v_array_1_dataout, v_array_0_dataout} = vld;
    dirty_out = dty;
    LRU_array_dataout = lru;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ld"}, {16'd0, v_ld, d_ld, t_ld, v_di}, 32'd0);
    chk({tag, "_sel"}, {16'd0, we_pk, din_pk}, 32'd0);
  endtask

  task automatic chk_hit(input string tag, input bit wr,
                         input int w, input logic [2:0] lru);
    chk({tag, "_resp"}, mem_resp, 1);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_lruld"}, LRU_array_load, 1);
    chk({tag, "_lru"}, LRU_array_datain, model_upd(lru, w));
    chk({tag, "_we"}, we_pk, wr ? selv(w, cpu_write_cache) : 8'd0);
    chk({tag, "_din"}, din_pk, wr ? selv(w, cpu_write_cache) : 8'd0);
    chk({tag, "_dld"}, {d_ld, d_di},
        wr ? {oneh(w), oneh(w)} : 8'd0);
    chk({tag, "_vt"}, {v_ld, t_ld}, 8'd0);
`ifdef DCACHE_PERF_CNT_EN
    exp_hits++;
`endif
  endtask

  // One full request from IDLE back to IDLE
  task automatic access(input bit wr, input int hw,
                        input logic [2:0] lru, input logic [3:0] vld,
                        input bit dty, input int dly);
    int v;
    logic [2:0] lru2;
    req_valid = 1'b1;
    req_read = !wr;
    req_write = wr;
    set_meta(-1, 4'd0, 1'b0, 3'd0);
    pmem_resp = 1'($urandom);
    settle();
    chk("idle_rd", read_array_flag, 1);
    chk("idle_stall", {stall, mem_resp, pmem_read, pmem_write}, 0);
    tick();
    pmem_resp = 1'b0;
    set_meta(hw, vld, dty, lru);
    if (hw >= 0) begin
      req_valid = 1'b0;
      settle();
      chk_hit("hit", wr, hw, lru);
      tick();
    end else begin
      v = model_victim(lru, vld);
`ifdef DCACHE_PERF_CNT_EN
      exp_misses++;
`endif
      settle();
      chk("miss_stall", stall, 1);
      chk("miss_resp", {mem_resp, LRU_array_load}, 0);
      chk("miss_pmem", {pmem_read, pmem_write}, 0);
      tick();
      req_valid = 1'($urandom);
      set_meta(-1, 4'($urandom), 1'($urandom), 3'($urandom));
      if (dty) begin
        for (int c = 0; c < dly; c++) begin
          pmem_resp = (c == dly - 1);
          settle();
          chk("wb_pmem", {pmem_write, pmem_read}, 2'b10);
          chk("wb_addr", pmem_address_MUX_sel, cache_write_mem);
          chk("wb_victim", dataout_MUX_sel, v);
          chk("wb_stall", {stall, mem_resp}, 2'b10);
          chk_quiet("wb");
          tick();
        end
      end
      for (int c = 0; c < dly; c++) begin
        pmem_resp = (c == dly - 1);
        settle();
        chk("fill_pmem", {pmem_write, pmem_read}, 2'b01);
        chk("fill_addr", pmem_address_MUX_sel, cache_read_mem);
        chk("fill_stall", {stall, mem_resp}, 2'b10);
        if (c == dly - 1) begin
          chk("fill_we", we_pk, selv(v, mem_write_cache));
          chk("fill_din", din_pk, selv(v, mem_write_cache));
          chk("fill_tag", t_ld, oneh(v));
          chk("fill_v", {v_ld, v_di}, {oneh(v), oneh(v)});
          chk("fill_d", {d_ld, d_di}, {oneh(v), 4'd0});
        end else begin
          chk_quiet("fill");
        end
        tick();
      end
      pmem_resp = 1'b1;
      settle();
      chk("rf_rd", read_array_flag, 1);
      chk("rf_stall", {stall, mem_resp}, 2'b10);
      chk("rf_pmem", {pmem_read, pmem_write}, 0);
      chk_quiet("rf");
      tick();
      pmem_resp = 1'b0;
      lru2 = 3'($urandom);
      req_valid = 1'b0;
      set_meta(v, 4'hF, 1'b0, lru2);
      settle();
      chk_hit("rhit", wr, v, lru2);
      tick();
    end
    set_meta(-1, 4'd0, 1'b0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    bit wr;
    int hw;
    logic [3:0] vld;
`ifdef DCACHE_PERF_CNT_EN
    exp_hits = 0;
    exp_misses = 0;
`endif
    rst = 1'b0;
    req_valid = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
    pmem_resp = 1'b0;
    set_meta(-1, 4'd0, 1'b0, 3'd0);
    #2;
    chk("rst_out", {read_array_flag, stall, mem_resp,
                    pmem_read, pmem_write}, 0);
    chk("rst_addr", pmem_address_MUX_sel, cache_read_mem);
    chk_quiet("rst");
`ifdef DCACHE_PERF_CNT_EN
    chk("rst_hc", hit_count, 0);
    chk("rst_mc", miss_count, 0);
`endif
    tick();
    tick();
    rst = 1'b1;

    access(0, 2, 3'b000, 4'hF, 0, 1);
    access(1, 1, 3'b011, 4'hF, 0, 1);
    access(0, -1, 3'b110, 4'hF, 0, 5);
    access(0, -1, 3'b000, 4'hF, 1, 3);
    access(1, -1, 3'b000, 4'b1011, 1, 2);
    access(1, -1, 3'b001, 4'hF, 0, 1);

    req_valid = 1'b1;
    req_read = 1'b1;
    req_write = 1'b0;
    tick();
    set_meta(0, 4'hF, 1'b0, 3'b111);
    settle();
    chk_hit("b2b0", 0, 0, 3'b111);
    tick();
    req_valid = 1'b0;
    set_meta(3, 4'hF, 1'b0, 3'b010);
    settle();
    chk_hit("b2b1", 0, 3, 3'b010);
    tick();
    set_meta(-1, 4'd0, 1'b0, 3'd0);

    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      hw = ($urandom % 2) ? int'($urandom % 4) : -1;
      vld = 4'($urandom);
      if (hw >= 0) vld[hw] = 1'b1;
      access(wr, hw, 3'($urandom), vld, 1'($urandom),
             $urandom_range(1, 4));
    end

    req_valid = 1'b1;
    req_read = 1'b1;
    tick();
    set_meta(-1, 4'hF, 1'b0, 3'b000);
    tick();
    req_valid = 1'b0;
    settle();
    chk("mid_fill", pmem_read, 1);
    rst = 1'b0;
    #1;
    chk("rst_fill_out", {pmem_read, pmem_write, stall,
                         read_array_flag, mem_resp}, 0);
    chk_quiet("rst_fill");
`ifdef DCACHE_PERF_CNT_EN
    chk("rst_fill_hc", hit_count, 0);
    chk("rst_fill_mc", miss_count, 0);
    exp_hits = 0;
    exp_misses = 0;
`endif
    tick();
    rst = 1'b1;
    settle();
    chk("post_rst_idle", {read_array_flag, stall, pmem_read}, 3'b100);
    tick();
    settle();
    chk("post_rst_hold", {read_array_flag, stall, pmem_read}, 3'b100);
    tick();

    access(0, 0, 3'b000, 4'hF, 0, 1);
    access(1, 3, 3'b100, 4'hF, 0, 1);
    access(0, 2, 3'b001, 4'hF, 0, 1);
    access(0, -1, 3'b010, 4'hF, 0, 2);
`ifdef DCACHE_PERF_CNT_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("cnt_4_1", {hit_count[15:0], miss_count[15:0]}, {16'd4, 16'd1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
